pulse_counter_param: RTL and testbench

//   Parametrised successor of the voltmeter cycle counter front end. Counts clk_i

---
 rtl/pulse_counter_pkg.sv | 16 +
 rtl/pc_enable_ctrl.sv | 51 +++++
 rtl/pulse_counter_param.sv | 73 +++++++
 tb/tb_pulse_counter_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pulse_counter_pkg.sv
// Shared constants for the parametrised pulse counter: mode encodings,
// default widths and the enable-controller state type.
package pulse_counter_pkg;

    localparam int unsigned COUNT_W_DEF  = 10;
    localparam int unsigned TERM_RST_DEF = 999;

    localparam logic MODE_FREERUN = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic {
        EN_IDLE = 1'b0,
        EN_RUN  = 1'b1
    } en_state_e;

endpackage : pulse_counter_pkg

// File: rtl/pc_enable_ctrl.sv
// Enable state machine for the pulse counter: stop/trigger/one-shot priority
// and the one-cycle done pulse that marks the end of a one-shot run.
module pc_enable_ctrl
    import pulse_counter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic trigger_i,
    input  logic stop_i,
    input  logic mode_i,
    input  logic wrap_i,
    output logic en_o,
    output logic done_o
);

    en_state_e state_q, state_d;
    logic      done_q, done_d;
    logic      oneshot_end;

    // A wrap in one-shot mode ends the run and beats any trigger at the same edge.
    assign oneshot_end = wrap_i && (mode_i == MODE_ONESHOT);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (stop_i) begin
            state_d = EN_IDLE;
        end else if (oneshot_end) begin
            state_d = EN_IDLE;
        end else if (trigger_i) begin
            state_d = EN_RUN;
        end
        if (oneshot_end) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EN_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign en_o   = (state_q == EN_RUN);
    assign done_o = done_q;

endmodule : pc_enable_ctrl

// File: rtl/pulse_counter_param.sv
// Enabled cycle counter with runtime-loadable terminal count, wrap carry,
// synchronous clear and one-shot mode.
module pulse_counter_param
    import pulse_counter_pkg::*;
#(
    parameter int unsigned COUNT_W  = COUNT_W_DEF,
    parameter int unsigned TERM_RST = TERM_RST_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trigger_i,
    input  logic               stop_i,
    input  logic               clear_i,
    input  logic               mode_i,
    input  logic               load_i,
    input  logic [COUNT_W-1:0] term_i,
    output logic               carry_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [COUNT_W-1:0] count_o
);

    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] term_q, term_d;
    logic               en;
    logic               wrap;
    logic               wrap_evt;

    // >= so that a terminal lowered below the current count wraps at once.
    assign wrap     = en && (count_q >= term_q);
    assign wrap_evt = wrap && !clear_i;

    pc_enable_ctrl u_enable_ctrl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .trigger_i (trigger_i),
        .stop_i    (stop_i),
        .mode_i    (mode_i),
        .wrap_i    (wrap_evt),
        .en_o      (en),
        .done_o    (done_o)
    );

    always_comb begin
        count_d = count_q;
        term_d  = term_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + COUNT_W'(1);
        end
        if (load_i) begin
            term_d = term_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            term_q  <= COUNT_W'(TERM_RST);
        end else begin
            count_q <= count_d;
            term_q  <= term_d;
        end
    end

    assign carry_o = wrap;
    assign busy_o  = en;
    assign count_o = count_q;

endmodule : pulse_counter_param

// File: tb/tb_pulse_counter_param.sv
// Directed bench for pulse_counter_param with hand-computed expectations.
module tb_pulse_counter_param;

    localparam int unsigned CW = 10;

    logic          clk;
    logic          rst;
    logic          trigger;
    logic          stop;
    logic          clear;
    logic          mode;
    logic          load;
    logic [CW-1:0] term;
    logic          carry;
    logic          done;
    logic          busy;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_counter_param #(.COUNT_W(CW), .TERM_RST(999)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .trigger_i (trigger),
        .stop_i    (stop),
        .clear_i   (clear),
        .mode_i    (mode),
        .load_i    (load),
        .term_i    (term),
        .carry_o   (carry),
        .done_o    (done),
        .busy_o    (busy),
        .count_o   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag, input int c, input bit cy,
                               input bit b, input bit d);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".carry"}, 32'(carry), 32'(cy));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        rst = 1'b1; trigger = 1'b0; stop = 1'b0; clear = 1'b0;
        mode = 1'b0; load = 1'b0; term = '0;

        // 1: reset, free-run with terminal 999
        tick();
        rst = 1'b0;
        check_state("reset", 0, 0, 0, 0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        check_state("t1_trig", 0, 0, 1, 0);
        tick(999);
        check_state("t1_top", 999, 1, 1, 0);
        tick();
        check_state("t1_wrap", 0, 0, 1, 0);
        tick(999);
        check_state("t1_top2", 999, 1, 1, 0);
        tick();
        check_state("t1_wrap2", 0, 0, 1, 0);

        // 2: one-shot with terminal 4
        stop = 1'b1; tick(); stop = 1'b0;
        check_state("t2_stop", 1, 0, 0, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        check_state("t2_clr", 0, 0, 0, 0);
        load = 1'b1; term = 10'd4; mode = 1'b1; tick(); load = 1'b0;
        check_state("t2_load", 0, 0, 0, 0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        check_state("t2_trig", 0, 0, 1, 0);
        tick(3);
        check_state("t2_cnt3", 3, 0, 1, 0);
        tick();
        check_state("t2_top", 4, 1, 1, 0);
        tick();
        check_state("t2_end", 0, 0, 0, 1);
        tick();
        check_state("t2_after", 0, 0, 0, 0);

        // 3: trigger and stop together while idle
        trigger = 1'b1; stop = 1'b1; tick(); trigger = 1'b0; stop = 1'b0;
        check_state("t3_both", 0, 0, 0, 0);

        // 4: lower terminal below current count
        mode = 1'b0;
        load = 1'b1; term = 10'd999; tick(); load = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        tick(50);
        check_state("t4_cnt50", 50, 0, 1, 0);
        load = 1'b1; term = 10'd10; tick(); load = 1'b0;
        check_state("t4_over", 51, 1, 1, 0);
        tick();
        check_state("t4_wrap", 0, 0, 1, 0);
        tick(10);
        check_state("t4_top", 10, 1, 1, 0);
        tick();
        check_state("t4_wrap2", 0, 0, 1, 0);

        // 5: clear while counting, then terminal 0
        load = 1'b1; term = 10'd999; tick(); load = 1'b0;
        check_state("t5_load", 1, 0, 1, 0);
        tick(499);
        check_state("t5_cnt500", 500, 0, 1, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        check_state("t5_clr", 0, 0, 1, 0);
        load = 1'b1; term = 10'd0; tick(); load = 1'b0;
        check_state("t5_term0", 1, 1, 1, 0);
        tick();
        check_state("t5_z1", 0, 1, 1, 0);
        tick();
        check_state("t5_z2", 0, 1, 1, 0);

        // 6: reset mid-run restores terminal 999
        load = 1'b1; term = 10'd999; tick(); load = 1'b0;
        check_state("t6_load", 0, 0, 1, 0);
        tick(300);
        check_state("t6_cnt300", 300, 0, 1, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_state("t6_rst", 0, 0, 0, 0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        tick(998);
        check_state("t6_998", 998, 0, 1, 0);
        tick();
        check_state("t6_top", 999, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_counter_param
